// File: rtl/logic_op_unit.sv
// ---------------------------------------------------------------------------
// logic_op_unit
//
// Registered bitwise logic unit with valid/ready handshake on both sides.
// Ops 0-5 (AND, OR, XOR, NAND, NOR, XNOR) produce one result per beat.
// Ops 6/7 (ACC_AND, ACC_OR) fold every operand of a burst, delimited by
// in_last, into a single result together with the number of beats folded.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   in_valid  operand beat valid
//   in_ready  unit can accept a beat this cycle
//   in_a      operand A (WIDTH)
//   in_b      operand B (WIDTH)
//   in_op     operation select, sampled on the first beat of a burst
//   in_last   final beat of a burst
//   out_valid result valid
//   out_ready downstream accepts the result
//   out_y     result (WIDTH)
//   out_cnt   beats folded into out_y (CNT_W)
// ---------------------------------------------------------------------------
module logic_op_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [CNT_W-1:0] out_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [2:0]         op_reg, op_next;
    logic [WIDTH-1:0]   acc_reg, acc_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               valid_reg, valid_next;
    logic [WIDTH-1:0]   y_reg, y_next;
    logic [CNT_W-1:0]   ycnt_reg, ycnt_next;

    logic               beat;
    logic [3:0]         truth;
    logic [WIDTH-1:0]   first_val;
    logic [WIDTH-1:0]   acc_val;
    logic [CNT_W-1:0]   cnt_sat;
    logic               is_acc_op;

    // A beat may load while the held result leaves in the same cycle.
    assign in_ready = !valid_reg || out_ready;
    assign beat     = in_valid && in_ready;

    // Each op is expressed as a 2-input truth table indexed by {a,b}.
    // The accumulate ops reuse AND/OR for their first beat.
    always_comb begin
        truth = 4'b0000;
        case (in_op)
            3'd0: truth = 4'b1000;   // AND
            3'd1: truth = 4'b1110;   // OR
            3'd2: truth = 4'b0110;   // XOR
            3'd3: truth = 4'b0111;   // NAND
            3'd4: truth = 4'b0001;   // NOR
            3'd5: truth = 4'b1001;   // XNOR
            3'd6: truth = 4'b1000;   // ACC_AND first beat
            3'd7: truth = 4'b1110;   // ACC_OR first beat
            default: truth = 4'b0000;
        endcase
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign first_val[gi] = truth[{in_a[gi], in_b[gi]}];
        end
    endgenerate

    assign is_acc_op = (in_op[2:1] == 2'b11);
    // op_reg[0] separates ACC_OR (7) from ACC_AND (6) during a burst.
    assign acc_val   = op_reg[0] ? (acc_reg | in_a | in_b) : (acc_reg & in_a & in_b);
    assign cnt_sat   = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_W'(1);

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        valid_next = valid_reg;
        y_next     = y_reg;
        ycnt_next  = ycnt_reg;

        if (valid_reg && out_ready) begin
            valid_next = 1'b0;
        end

        if (beat) begin
            case (state_reg)
                IDLE: begin
                    op_next = in_op;
                    if (is_acc_op) begin
                        acc_next = first_val;
                        cnt_next = CNT_W'(1);
                    end
                    if (!is_acc_op || in_last) begin
                        y_next     = first_val;
                        ycnt_next  = CNT_W'(1);
                        valid_next = 1'b1;
                    end else begin
                        state_next = ACCUM;
                    end
                end
                ACCUM: begin
                    cnt_next = cnt_sat;
                    if (in_last) begin
                        y_next     = acc_val;
                        ycnt_next  = cnt_sat;
                        valid_next = 1'b1;
                        acc_next   = '0;
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        acc_next = acc_val;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            op_reg    <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            valid_reg <= 1'b0;
            y_reg     <= '0;
            ycnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            valid_reg <= valid_next;
            y_reg     <= y_next;
            ycnt_reg  <= ycnt_next;
        end
    end

    assign out_valid = valid_reg;
    assign out_y     = y_reg;
    assign out_cnt   = ycnt_reg;

endmodule

// File: tb/tb_logic_op_unit.sv
// ---------------------------------------------------------------------------
// tb_logic_op_unit
//
// Directed-vector bench for logic_op_unit. Instance u_dut uses the default
// widths; u_sat uses CNT_W=2 to exercise counter saturation.
// ---------------------------------------------------------------------------
module tb_logic_op_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic [2:0] in_op = '0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_y;
    logic [7:0] out_cnt;

    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_a = '0;
    logic [7:0] s_b = '0;
    logic [2:0] s_op = '0;
    logic       s_last = 1'b0;
    logic       s_out_valid;
    logic       s_out_ready = 1'b1;
    logic [7:0] s_out_y;
    logic [1:0] s_out_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    logic_op_unit #(.WIDTH(8), .CNT_W(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_cnt   (out_cnt)
    );

    logic_op_unit #(.WIDTH(8), .CNT_W(2)) u_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_valid),
        .in_ready  (s_ready),
        .in_a      (s_a),
        .in_b      (s_b),
        .in_op     (s_op),
        .in_last   (s_last),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_y     (s_out_y),
        .out_cnt   (s_out_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Present one beat at the falling edge, let it clock in, then release.
    task automatic beat(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic last);
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Vectors for the back-to-back single-beat ops with a=A5, b=0F.
    logic [2:0] vec_op  [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [7:0] vec_exp [5] = '{8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55};

    // Saturation burst operands; OR of all ten is FF.
    logic [7:0] sat_a [5] = '{8'h01, 8'h04, 8'h10, 8'h40, 8'h00};
    logic [7:0] sat_b [5] = '{8'h02, 8'h08, 8'h20, 8'h00, 8'h80};

    initial begin
        // Reset state
        #2;
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out_y", 32'(out_y), 32'd0);
        check_val("rst_out_cnt", 32'(out_cnt), 32'd0);
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: single AND
        beat(3'd0, 8'hF0, 8'h3C, 1'b0);
        check_val("and_valid", 32'(out_valid), 32'd1);
        check_val("and_y", 32'(out_y), 32'h30);
        check_val("and_cnt", 32'(out_cnt), 32'd1);

        // 2: back-to-back ops 1-5
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_op    = vec_op[i];
            in_a     = 8'hA5;
            in_b     = 8'h0F;
            in_last  = 1'b0;
            check_val($sformatf("b2b_ready_op%0d", vec_op[i]), 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            check_val($sformatf("b2b_valid_op%0d", vec_op[i]), 32'(out_valid), 32'd1);
            check_val($sformatf("b2b_y_op%0d", vec_op[i]), 32'(out_y), 32'(vec_exp[i]));
        end
        idle_cycle();
        check_val("b2b_drain", 32'(out_valid), 32'd0);

        // 3: ACC_AND burst, in_op changed mid-burst
        beat(3'd6, 8'hFF, 8'hF7, 1'b0);
        check_val("accand_b1_valid", 32'(out_valid), 32'd0);
        beat(3'd1, 8'h7F, 8'hFF, 1'b0);
        check_val("accand_b2_valid", 32'(out_valid), 32'd0);
        beat(3'd1, 8'hFE, 8'hFF, 1'b1);
        check_val("accand_valid", 32'(out_valid), 32'd1);
        check_val("accand_y", 32'(out_y), 32'h76);
        check_val("accand_cnt", 32'(out_cnt), 32'd3);
        idle_cycle();

        // 4: backpressure
        @(negedge clk);
        out_ready = 1'b0;
        beat(3'd0, 8'hFF, 8'h0F, 1'b0);
        check_val("bp_held_y", 32'(out_y), 32'h0F);
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 3'd1;
        in_a     = 8'h11;
        in_b     = 8'h22;
        in_last  = 1'b0;
        #1;
        check_val("bp_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check_val("bp_stable_valid", 32'(out_valid), 32'd1);
        check_val("bp_stable_y", 32'(out_y), 32'h0F);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check_val("bp_ready_high", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_val("bp_new_valid", 32'(out_valid), 32'd1);
        check_val("bp_new_y", 32'(out_y), 32'h33);
        check_val("bp_new_cnt", 32'(out_cnt), 32'd1);
        idle_cycle();

        // 5: reset mid ACC_OR burst
        beat(3'd7, 8'h01, 8'h02, 1'b0);
        beat(3'd7, 8'h04, 8'h08, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("rstmid_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        beat(3'd0, 8'hF0, 8'hFF, 1'b0);
        check_val("post_rst_valid", 32'(out_valid), 32'd1);
        check_val("post_rst_y", 32'(out_y), 32'hF0);
        check_val("post_rst_cnt", 32'(out_cnt), 32'd1);
        // Asynchronous reset clears a held result without a clock edge.
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check_val("async_rst_valid", 32'(out_valid), 32'd0);
        check_val("async_rst_y", 32'(out_y), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;

        // 6: saturating counter on CNT_W=2 instance
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_op    = 3'd7;
            s_a     = sat_a[i];
            s_b     = sat_b[i];
            s_last  = (i == 4);
            @(posedge clk);
            #1;
            s_valid = 1'b0;
            if (i == 3) check_val("sat_no_early_valid", 32'(s_out_valid), 32'd0);
        end
        check_val("sat_valid", 32'(s_out_valid), 32'd1);
        check_val("sat_y", 32'(s_out_y), 32'hFF);
        check_val("sat_cnt", 32'(s_out_cnt), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/logic_op_unit.md
Name: logic_op_unit

Overview:
- Parametrised, registered successor to the single-bit AND/OR gate blocks.
- Applies one of eight selectable bitwise or accumulating logic operations to WIDTH-bit operand pairs.
- Uses a valid/ready handshake and drives one registered output stage.
- Sits between a stimulus source and a checker or downstream datapath. Accumulate modes reduce a multi-beat burst, delimited by in_last, to a single result.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).
- CNT_W, 8, width of the beat counter reported with each result (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit can accept a beat this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  3  operation select; sampled on the first beat of a burst.
- in_last  input  1  final beat of a burst; every beat is last in single-beat ops.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_y  output  WIDTH  result.
- out_cnt  output  CNT_W  beats folded into out_y (1 for single-beat ops).

Behaviour:
- Op encoding: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ACC_AND, 7 ACC_OR.
- Beat transfer: occurs when in_valid && in_ready. Result transfer: occurs when out_valid && out_ready.
- in_ready = !out_valid || out_ready. This is combinational, so a new beat can load while the held result leaves in the same cycle.
- Reset, asserted asynchronously: out_valid=0, out_y=0, out_cnt=0, acc=0, cnt=0, op_q=0, state=IDLE.
- Reset takes effect immediately, even mid-burst. Any partial accumulation and any held result are discarded.
- State IDLE, beat accepted:
  - op_q <= in_op.
  - Ops 0-5: out_y <= f(in_a,in_b), out_cnt <= 1, out_valid <= 1 next cycle (latency 1). State stays IDLE. in_last is ignored.
  - Op 6: acc <= in_a & in_b. Op 7: acc <= in_a | in_b. cnt <= 1.
  - For ops 6/7 with in_last=1: out_y <= that value, out_cnt <= 1, out_valid <= 1, stay in IDLE. With in_last=0: go to ACCUM.
- State ACCUM, beat accepted:
  - in_op is ignored; op_q holds.
  - ACC_AND: v = acc & in_a & in_b. ACC_OR: v = acc | in_a | in_b.
  - Counter saturates: cnt <= (cnt==all-ones) ? cnt : cnt+1.
  - in_last=0: acc <= v, no output.
  - in_last=1: out_y <= v, out_cnt <= saturated count, out_valid <= 1, acc <= 0, cnt <= 0, state <= IDLE.
- Backpressure in ACCUM: non-last beats still require in_ready. The unit never accepts a beat it could not retire.
- out_valid deasserts the cycle after a result transfer, unless a new result loads in that same cycle.
- Once out_valid=1, out_y and out_cnt stay stable until the result transfers.
- No combinational path from in_a/in_b to out_y.
- in_valid=0 in any state: no state change.

Test Plan:
1. WIDTH=8, op 0, a=8'hF0, b=8'h3C, out_ready=1 -> next cycle out_valid=1, out_y=8'h30, out_cnt=1.
2. Ops 1-5 with a=8'hA5, b=8'h0F, back-to-back beats -> results in order: OR 8'hAF, XOR 8'hAA, NAND 8'hFA, NOR 8'h50, XNOR 8'h55. One result per cycle; in_ready stays 1.
3. ACC_AND burst of 3 beats, pairs (FF,F7), (7F,FF), (FE,FF), last on beat 3 -> single result out_y=8'h76, out_cnt=3. No out_valid before beat 3. in_op changed to 1 on beat 2 has no effect.
4. Backpressure: out_ready=0 with a result held, then op 1 beat offered -> in_ready=0 and out_y stays stable. Raise out_ready -> held result transfers and the new beat loads in the same cycle.
5. Reset mid-ACC_OR burst after 2 beats -> out_valid=0 immediately. A following single op-0 beat gives the correct result with out_cnt=1.
6. CNT_W=2, ACC_OR burst of 5 beats -> out_cnt=3 (saturated), out_y equals OR of all 10 operands.
